// File: rtl/hisoc_test_sequencer.sv
// hisoc_test_sequencer
// Streams a program image into the instruction ROM while the core is held in
// reset. It then releases core reset and enable in a fixed order, and watches
// register writebacks for the x26 end-of-test marker. The verdict comes from
// x27 (pass when x27 == 1) and the failing test number comes from x3. A run
// timeout ends a run that never reaches the marker.

module hisoc_test_sequencer #(
  parameter int ADDR_W      = 10,
  parameter int CPU_WIDTH   = 32,
  parameter int SETTLE_CYC  = 5,
  parameter int DRAIN_CYC   = 4,
  parameter int TIMEOUT_CYC = 2000
) (
  input  logic                 clk,
  input  logic                 rst,
  // program word stream
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [CPU_WIDTH-1:0] s_data,
  input  logic                 s_last,
  // instruction ROM write port
  output logic                 rom_we,
  output logic [ADDR_W-1:0]    rom_addr,
  output logic [CPU_WIDTH-1:0] rom_wdata,
  // core control
  output logic                 core_rst,
  output logic                 core_enable,
  // writeback observation
  input  logic                 wb_en,
  input  logic [4:0]           wb_rd,
  input  logic [CPU_WIDTH-1:0] wb_data,
  // status
  input  logic                 clear,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 timeout,
  output logic                 ovf,
  output logic [CPU_WIDTH-1:0] fail_testnum
);

  typedef enum logic [2:0] {IDLE, LOAD, SETTLE, RUN, DRAIN, DONE} state_t;

  // Counter widths carry one spare code so that a zero parameter still
  // yields a legal width.
  localparam int SET_W = $clog2(SETTLE_CYC + 2);
  localparam int DRN_W = $clog2(DRAIN_CYC + 2);
  localparam int RUN_W = $clog2(TIMEOUT_CYC + 2);

  localparam logic [ADDR_W-1:0]    WCNT_MAX  = '1;
  localparam logic [CPU_WIDTH-1:0] WB_ONE    = CPU_WIDTH'(1);
  localparam logic [SET_W-1:0]     SET_LAST  = SET_W'(SETTLE_CYC);
  localparam logic [DRN_W-1:0]     DRN_LAST  = DRN_W'(DRAIN_CYC - 1);
  localparam logic [RUN_W-1:0]     RUN_LAST  = RUN_W'(TIMEOUT_CYC - 1);

  state_t               state;
  logic [ADDR_W-1:0]    wcnt;
  logic [SET_W-1:0]     settle_cnt;
  logic [DRN_W-1:0]     drain_cnt;
  logic [RUN_W-1:0]     run_cnt;
  logic [CPU_WIDTH-1:0] sh_x27;
  logic [CPU_WIDTH-1:0] sh_x3;

  logic                 accept;
  logic                 at_top;
  logic                 wb_live;
  logic                 cap_x27;
  logic                 cap_x3;
  logic                 marker;
  logic [CPU_WIDTH-1:0] x27_now;
  logic [CPU_WIDTH-1:0] x3_now;

  // s_ready is a register that is high exactly in IDLE/LOAD, so the handshake
  // never depends on s_valid.
  assign accept  = s_valid && s_ready;
  assign at_top  = (wcnt == WCNT_MAX);

  // Writebacks only count while the core runs. Register x0 is never observed.
  assign wb_live = wb_en && (wb_rd != 5'd0) && ((state == RUN) || (state == DRAIN));
  assign cap_x27 = wb_live && (wb_rd == 5'd27);
  assign cap_x3  = wb_live && (wb_rd == 5'd3);
  assign marker  = wb_live && (wb_rd == 5'd26) && (wb_data == WB_ONE);

  // The verdict sees a writeback that lands in the final DRAIN cycle.
  assign x27_now = cap_x27 ? wb_data : sh_x27;
  assign x3_now  = cap_x3  ? wb_data : sh_x3;

  // Sequencer FSM with registered control, ROM write and status outputs.
  // NOTE: every register in this block uses non-blocking assignment, so all
  // branches see pre-edge values. Reset is synchronous, so it is handled
  // inside the clocked block rather than in the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      s_ready      <= 1'b1;
      core_rst     <= 1'b1;
      core_enable  <= 1'b0;
      rom_we       <= 1'b0;
      rom_addr     <= '0;
      rom_wdata    <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      timeout      <= 1'b0;
      ovf          <= 1'b0;
      fail_testnum <= '0;
      wcnt         <= '0;
      settle_cnt   <= '0;
      drain_cnt    <= '0;
      run_cnt      <= '0;
      sh_x27       <= '0;
      sh_x3        <= '0;
    end else begin
      // ROM write lags the accepted beat by one cycle.
      rom_we <= accept;
      if (accept) begin
        rom_addr  <= wcnt;
        rom_wdata <= s_data;
        if (!at_top) begin
          wcnt <= wcnt + 1'b1;
        end
      end

      if (cap_x27) begin
        sh_x27 <= wb_data;
      end
      if (cap_x3) begin
        sh_x3 <= wb_data;
      end

      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            busy <= 1'b1;
            if (s_last || at_top) begin
              // The top address is always the final word of the image.
              state      <= SETTLE;
              s_ready    <= 1'b0;
              settle_cnt <= '0;
              if (!s_last) begin
                ovf <= 1'b1;
              end
            end else begin
              state <= LOAD;
            end
          end
        end

        SETTLE: begin
          // The first SETTLE cycle keeps core reset so the last ROM write
          // lands while the core is still held in reset.
          core_rst <= 1'b0;
          if (settle_cnt == SET_LAST) begin
            state       <= RUN;
            core_enable <= 1'b1;
          end else begin
            settle_cnt <= settle_cnt + 1'b1;
          end
        end

        RUN: begin
          if (marker) begin
            state     <= DRAIN;
            drain_cnt <= '0;
          end else if (run_cnt == RUN_LAST) begin
            state       <= DONE;
            timeout     <= 1'b1;
            pass        <= 1'b0;
            core_enable <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b1;
          end else begin
            run_cnt <= run_cnt + 1'b1;
          end
        end

        DRAIN: begin
          if (drain_cnt == DRN_LAST) begin
            state        <= DONE;
            pass         <= (x27_now == WB_ONE);
            fail_testnum <= x3_now;
            core_enable  <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt + 1'b1;
          end
        end

        DONE: begin
          if (clear) begin
            state        <= IDLE;
            s_ready      <= 1'b1;
            core_rst     <= 1'b1;
            done         <= 1'b0;
            wcnt         <= '0;
            run_cnt      <= '0;
            sh_x27       <= '0;
            sh_x3        <= '0;
            ovf          <= 1'b0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            fail_testnum <= '0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hisoc_test_sequencer.sv
// Self-checking bench for hisoc_test_sequencer.
// Expected ROM writes, handshake and settle timing come from a word index
// that the bench keeps itself. Run verdicts come from a writeback list that
// is generated in advance. The list is scanned for the first marker, the
// done cycle is marker + 1 + DRAIN_CYC, and the verdict uses the last x27 and
// x3 writes up to that cycle.

module tb_hisoc_test_sequencer;

  localparam int ADDR_W      = 10;
  localparam int CPU_WIDTH   = 32;
  localparam int SETTLE_CYC  = 5;
  localparam int DRAIN_CYC   = 4;
  localparam int TIMEOUT_CYC = 2000;

  typedef struct packed {
    logic        en;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 s_valid;
  logic                 s_ready;
  logic [CPU_WIDTH-1:0] s_data;
  logic                 s_last;
  logic                 rom_we;
  logic [ADDR_W-1:0]    rom_addr;
  logic [CPU_WIDTH-1:0] rom_wdata;
  logic                 core_rst;
  logic                 core_enable;
  logic                 wb_en;
  logic [4:0]           wb_rd;
  logic [CPU_WIDTH-1:0] wb_data;
  logic                 clear;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 timeout;
  logic                 ovf;
  logic [CPU_WIDTH-1:0] fail_testnum;

  int          n_checks;
  int          n_fail;
  logic [31:0] img[$];
  wb_t         wbq[$];
  bit          load_ovf;

  hisoc_test_sequencer #(
    .ADDR_W      (ADDR_W),
    .CPU_WIDTH   (CPU_WIDTH),
    .SETTLE_CYC  (SETTLE_CYC),
    .DRAIN_CYC   (DRAIN_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_data       (s_data),
    .s_last       (s_last),
    .rom_we       (rom_we),
    .rom_addr     (rom_addr),
    .rom_wdata    (rom_wdata),
    .core_rst     (core_rst),
    .core_enable  (core_enable),
    .wb_en        (wb_en),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .clear        (clear),
    .busy         (busy),
    .done         (done),
    .pass         (pass),
    .timeout      (timeout),
    .ovf          (ovf),
    .fail_testnum (fail_testnum)
  );

  always #5 clk = ~clk;

  // Safety net: the run must never hang.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no end of test, expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // {s_ready, core_rst, core_enable, busy, done}
  function automatic logic [4:0] flags();
    return {s_ready, core_rst, core_enable, busy, done};
  endfunction

  function automatic wb_t mk(input bit en, input int rd, input logic [31:0] d);
    wb_t w;
    w.en   = en;
    w.rd   = 5'(rd);
    w.data = d;
    return w;
  endfunction

  task automatic drive_noise();
    wb_en   = 1'($urandom_range(1, 0));
    wb_rd   = 5'($urandom);
    wb_data = $urandom;
  endtask

  // Stream an image and check every ROM write. Then check SETTLE timing up to
  // the cycle where core_enable rises.
  task automatic load_image(input int n_words, input bit use_last, input int gap_pct,
                            input bit hold_valid);
    int          idx;
    int          guard;
    bit          fin;
    bit          v;
    logic [31:0] d;
    idx      = 0;
    guard    = 0;
    fin      = 1'b0;
    load_ovf = 1'b0;
    while (!fin && guard < 5000) begin
      guard++;
      v       = (int'($urandom_range(99, 0)) >= gap_pct);
      d       = (idx < img.size()) ? img[idx] : $urandom;
      s_valid = v;
      s_data  = d;
      s_last  = use_last && (idx == n_words - 1);
      clear   = 1'($urandom_range(1, 0));
      drive_noise();
      check("load_ready", 64'(s_ready), 64'(1'b1));
      tick();
      if (v) begin
        check("load_write", 64'({rom_we, rom_addr, rom_wdata}),
              64'({1'b1, ADDR_W'(idx), d}));
        if (s_last || idx == (1 << ADDR_W) - 1) begin
          fin      = 1'b1;
          load_ovf = !s_last;
        end
        idx++;
      end else begin
        check("load_gap_we", 64'(rom_we), 64'(1'b0));
      end
    end
    check("load_finished", 64'(fin), 64'(1'b1));
    // First SETTLE cycle: core still in reset, stream closed.
    s_valid = hold_valid;
    s_last  = 1'b0;
    clear   = 1'b1;
    check("settle_first", 64'({flags(), ovf}), 64'({5'b01010, load_ovf}));
    for (int j = 1; j <= SETTLE_CYC + 1; j++) begin
      // Writebacks before RUN must not reach the verdict.
      wb_en   = 1'b1;
      wb_rd   = (j % 2 == 1) ? 5'd27 : 5'd3;
      wb_data = 32'd1;
      tick();
      if (j <= SETTLE_CYC)
        check("settle_hold", 64'({flags(), rom_we}), 64'({5'b00010, 1'b0}));
      else
        check("enable_rise", 64'({flags(), rom_we}), 64'({5'b00110, 1'b0}));
    end
    clear   = 1'b0;
    s_valid = 1'b0;
    wb_en   = 1'b0;
  endtask

  // Play wbq from RUN cycle 0, then check the verdict, the hold in DONE and
  // the effect of clear.
  task automatic run_and_check(input string tag);
    int          marker_idx;
    int          done_idx;
    bit          exp_pass;
    bit          exp_to;
    logic [31:0] x27;
    logic [31:0] x3;
    marker_idx = -1;
    for (int i = 0; i < wbq.size() && i < TIMEOUT_CYC; i++)
      if (marker_idx < 0 && wbq[i].en && wbq[i].rd == 5'd26 && wbq[i].data == 32'd1)
        marker_idx = i;
    x27 = '0;
    x3  = '0;
    if (marker_idx < 0) begin
      done_idx = TIMEOUT_CYC;
      exp_to   = 1'b1;
      exp_pass = 1'b0;
    end else begin
      done_idx = marker_idx + 1 + DRAIN_CYC;
      exp_to   = 1'b0;
      for (int i = 0; i < done_idx && i < wbq.size(); i++) begin
        if (wbq[i].en && wbq[i].rd == 5'd27) x27 = wbq[i].data;
        if (wbq[i].en && wbq[i].rd == 5'd3)  x3  = wbq[i].data;
      end
      exp_pass = (x27 == 32'd1);
    end

    for (int t = 0; t < done_idx; t++) begin
      if (t < wbq.size()) begin
        wb_en   = wbq[t].en;
        wb_rd   = wbq[t].rd;
        wb_data = wbq[t].data;
      end else begin
        wb_en = 1'b0;
      end
      tick();
      check($sformatf("%s_cycle%0d", tag, t + 1), 64'(flags()),
            64'((t + 1 < done_idx) ? 5'b00110 : 5'b00001));
    end
    wb_en = 1'b0;
    check($sformatf("%s_verdict", tag), 64'({done, pass, timeout}),
          64'({1'b1, exp_pass, exp_to}));
    if (!exp_to)
      check($sformatf("%s_testnum", tag), 64'(fail_testnum), 64'(x3));

    for (int k = 0; k < 3; k++) begin
      drive_noise();
      tick();
      check($sformatf("%s_hold", tag), 64'({flags(), pass, timeout, ovf}),
            64'({5'b00001, exp_pass, exp_to, load_ovf}));
    end
    wb_en = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check($sformatf("%s_clear", tag), 64'({flags(), pass, timeout, ovf, fail_testnum}),
          64'({5'b11000, 3'b000, 32'd0}));
  endtask

  task automatic gen_random_run();
    int          m;
    int          sel;
    logic [4:0]  rd;
    logic [31:0] d;
    m = int'($urandom_range(60, 3));
    wbq.delete();
    for (int i = 0; i < m + DRAIN_CYC + 4; i++) begin
      sel = int'($urandom_range(5, 0));
      case (sel)
        0:       rd = 5'd0;
        1:       rd = 5'd3;
        2, 3:    rd = 5'd27;
        4:       rd = 5'd26;
        default: rd = 5'($urandom);
      endcase
      d = (rd == 5'd27) ? 32'($urandom_range(2, 0)) : $urandom;
      // A random x26 write never carries the marker value.
      if (rd == 5'd26) d = d & 32'hFFFF_FFFE;
      wbq.push_back(mk(1'($urandom_range(1, 0)), int'(rd), d));
    end
    wbq[m] = mk(1'b1, 26, 32'd1);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    wb_en    = 1'b0;
    wb_rd    = '0;
    wb_data  = '0;
    clear    = 1'b0;
    load_ovf = 1'b0;
    tick();
    tick();
    check("reset_ctrl", 64'({flags(), rom_we, rom_addr, rom_wdata}),
          64'({5'b11000, 1'b0, 10'd0, 32'd0}));
    check("reset_status", 64'({pass, timeout, ovf, fail_testnum}), 64'd0);
    rst = 1'b0;

    // Three-word program, back to back; x3=5, x27=1, marker -> pass.
    img = '{32'h0000_0013, 32'h0010_0D13, 32'h0010_0D93};
    load_image(3, 1'b1, 0, 1'b0);
    img.delete();
    wbq.delete();
    wbq.push_back(mk(1'b1, 3, 32'd5));
    wbq.push_back(mk(1'b1, 27, 32'd1));
    wbq.push_back(mk(1'b1, 26, 32'd1));
    run_and_check("dir_pass");

    // x27 overwritten with 0 during DRAIN -> fail with test number 7.
    load_image(5, 1'b1, 30, 1'b0);
    wbq.delete();
    wbq.push_back(mk(1'b1, 3, 32'd7));
    wbq.push_back(mk(1'b1, 27, 32'd1));
    wbq.push_back(mk(1'b1, 26, 32'd1));
    wbq.push_back(mk(1'b0, 0, 32'd0));
    wbq.push_back(mk(1'b1, 27, 32'd0));
    run_and_check("dir_drain_fail");

    // No marker at all -> timeout.
    load_image(2, 1'b1, 0, 1'b0);
    wbq.delete();
    run_and_check("timeout");

    // Marker in the last allowed RUN cycle -> DRAIN path wins.
    load_image(1, 1'b1, 0, 1'b0);
    wbq.delete();
    for (int i = 0; i < TIMEOUT_CYC - 1; i++) wbq.push_back(mk(1'b0, 0, 32'd0));
    wbq.push_back(mk(1'b1, 26, 32'd1));
    run_and_check("marker_vs_timeout");

    // Randomized images and writeback streams.
    for (int r = 0; r < 4; r++) begin
      load_image(int'($urandom_range(20, 1)), 1'b1, 30, 1'b0);
      gen_random_run();
      run_and_check($sformatf("rand%0d", r));
    end

    // Overflow: full image without s_last, valid kept high through SETTLE.
    load_image(2000, 1'b0, 0, 1'b1);
    gen_random_run();
    run_and_check("overflow");

    // Reset while running abandons everything.
    load_image(2, 1'b1, 0, 1'b0);
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    check("rst_in_run", 64'({flags(), rom_we, rom_addr, ovf, pass, timeout}),
          64'({5'b11000, 1'b0, 10'd0, 3'b000}));
    rst = 1'b0;
    load_ovf = 1'b0;

    // Recovery: a fresh load starts again at address 0.
    load_image(4, 1'b1, 20, 1'b0);
    gen_random_run();
    run_and_check("after_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/hisoc_test_sequencer.md
# hisoc_test_sequencer

Synthesizable program-load and test-verdict sequencer sitting between an external program source and the HISOC core. It streams a program image into the instruction ROM while holding the core in reset, then releases reset and enable in a fixed sequence. It watches register-file writebacks for the x26 end-of-test marker and latches a pass/fail verdict from x27, with the failing test number from x3. It also provides a run timeout, so regression runs without a simulator-side checker.

## Interface
- `ADDR_W`, 10: instruction ROM word-address width.
- `CPU_WIDTH`, 32: data width of program words and writeback data.
- `SETTLE_CYC`, 5: cycles between core reset release and enable assertion.
- `DRAIN_CYC`, 4: cycles after the x26 marker before the verdict is latched.
- `TIMEOUT_CYC`, 2000: maximum RUN cycles before a timeout is declared.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `s_valid` in 1, `s_ready` out 1, `s_data` in CPU_WIDTH, `s_last` in 1: program word stream.
- `rom_we` out 1, `rom_addr` out ADDR_W, `rom_wdata` out CPU_WIDTH: instruction ROM write port.
- `core_rst` out 1: active-high reset to the core.
- `core_enable` out 1: core enable.
- `wb_en` in 1, `wb_rd` in 5, `wb_data` in CPU_WIDTH: core register writeback observation.
- `clear` in 1: pulse that returns the block from DONE to IDLE.
- `busy` out 1, `done` out 1, `pass` out 1, `timeout` out 1, `ovf` out 1, `fail_testnum` out CPU_WIDTH: status outputs.

## Operation
- States: IDLE, LOAD, SETTLE, RUN, DRAIN, DONE.
- IDLE / LOAD:
  - `s_ready`=1, `core_rst`=1, `core_enable`=0.
  - Each accepted beat (`s_valid && s_ready`) writes word counter `wcnt` and increments it; the first beat moves IDLE to LOAD.
  - A beat with `s_last`=1 moves to SETTLE.
  - A beat accepted at `wcnt`=2^ADDR_W-1 without `s_last` is written, treated as last, and sets sticky `ovf`=1. The counter never wraps.
- SETTLE:
  - `s_ready`=0.
  - First cycle: `core_rst`=1.
  - Next SETTLE_CYC cycles: `core_rst`=0, `core_enable`=0.
  - Then go to RUN.
- RUN:
  - `core_rst`=0, `core_enable`=1.
  - Shadow registers: `wb_en && wb_rd==27` captures `sh_x27`; `wb_en && wb_rd==3` captures `sh_x3`.
  - `wb_en && wb_rd==26 && wb_data==1` enters DRAIN.
  - `run_cnt` counts RUN cycles; reaching TIMEOUT_CYC-1 with no marker goes to DONE with `timeout`=1, `pass`=0.
  - If the marker and the timeout fall in the same cycle, the marker wins.
- DRAIN:
  - Core stays enabled; shadow capture continues.
  - After DRAIN_CYC cycles go to DONE with `pass`=(`sh_x27`==1) and `fail_testnum`=`sh_x3`.
- DONE:
  - `core_enable`=0, `core_rst`=0; `done`=1.
  - Verdict outputs are held stable.
  - `clear` goes to IDLE and zeroes `wcnt`, `run_cnt`, shadows, `ovf`, `pass`, `timeout`, `fail_testnum`.
  - `clear` in any other state is ignored.
- Writebacks with `wb_rd`==0 are always ignored. Writebacks outside RUN/DRAIN are ignored.
- `busy`=1 in every state except IDLE and DONE.

## Timing
- Reset values:
  - state=IDLE, `s_ready`=1, `core_rst`=1.
  - `core_enable`, `rom_we`, `rom_addr`, `rom_wdata`, `done`, `pass`, `timeout`, `ovf`, `busy`, `fail_testnum` = 0.
- ROM write is registered: the beat accepted in cycle N gives `rom_we`=1 with its address and data in cycle N+1. The last beat's write therefore lands in SETTLE cycle 1, while `core_rst`=1.
- Sustained one beat per cycle; `s_ready` is not dependent on `s_valid`.
- From acceptance of the last beat at cycle N:
  - `core_rst` falls at N+2.
  - `core_enable` rises at N+2+SETTLE_CYC.
- Marker observed at cycle M: `done` rises at M+1+DRAIN_CYC.
- Reset mid-operation (any state): everything returns to reset values the next edge; any partial ROM image is abandoned.

## Test plan
- Load 3 words (0x00000013, 0x00100D13, 0x00100D93; `s_last` on the third), `s_valid` held high:
  - `rom_we` pulses for addresses 0,1,2 on consecutive cycles.
  - `core_enable` rises exactly SETTLE_CYC+2 cycles after the last beat.
- In RUN, drive wb x3=5, then x27=1, then x26=1:
  - `done` rises 5 cycles after the x26 writeback, with `pass`=1 and `fail_testnum`=5.
- Drive x3=7, x26=1, then x27=0 during DRAIN: `pass`=0, `fail_testnum`=7 (the DRAIN-phase capture takes effect).
- No marker: `timeout`=1, `pass`=0 and `done`=1 after TIMEOUT_CYC RUN cycles. Marker and timeout in the same cycle: DRAIN path taken, `timeout`=0.
- Stream 1024 words with no `s_last`, ADDR_W=10: `ovf`=1, transition to SETTLE after address 1023, and no write beyond 1023.
- Assert `rst` in RUN: IDLE with `core_rst`=1 next cycle. `clear` in DONE: status zeroed and `s_ready`=1.
